// File: rtl/fetch_pipeline_pkg.sv
// Shared definitions for the instruction-fetch front end: default widths,
// the NOP opcode and the legal pipeline-depth range.
package fetch_pipeline_pkg;

  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned INSTR_W_DEF = 8;
  localparam int unsigned STAGES_DEF  = 1;
  localparam int unsigned STAGES_MIN  = 1;
  localparam int unsigned STAGES_MAX  = 4;

  localparam logic [7:0] NOP_OP_DEF = 8'hC8;

  // True when a pipeline depth is one the front end supports.
  function automatic bit stages_ok(input int unsigned n);
    return (n >= STAGES_MIN) && (n <= STAGES_MAX);
  endfunction

endpackage

// File: rtl/fetch_pipeline_if.sv
// Sequencer/memory/decoder-facing signals of the fetch front end.
// master = environment (sequencer, memory, decoder), slave = fetch_pipeline.
interface fetch_pipeline_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 8
);

  logic               stall;
  logic               jmp;
  logic               jmp_nz;
  logic               zero_flag;
  logic [ADDR_W-1:0]  jmp_addr;
  logic [INSTR_W-1:0] pm_data;
  logic [ADDR_W-1:0]  pm_addr;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               flush;

  modport master (
    output stall, jmp, jmp_nz, zero_flag, jmp_addr, pm_data,
    input  pm_addr, pc, instr, instr_pc, instr_valid, flush
  );

  modport slave (
    input  stall, jmp, jmp_nz, zero_flag, jmp_addr, pm_data,
    output pm_addr, pc, instr, instr_pc, instr_valid, flush
  );

endinterface

// File: rtl/fetch_stage.sv
// One fetch pipeline slot: {valid, instr, pc} with clear > hold > load priority.
module fetch_stage #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               load,
  input  logic               d_valid,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [ADDR_W-1:0]  d_pc,
  output logic               q_valid,
  output logic [INSTR_W-1:0] q_instr,
  output logic [ADDR_W-1:0]  q_pc
);

  // Clearing only drops valid; the data fields of an empty slot are don't-care.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_valid <= 1'b0;
      q_instr <= '0;
      q_pc    <= '0;
    end else if (clear) begin
      q_valid <= 1'b0;
    end else if (load) begin
      q_valid <= d_valid;
      q_instr <= d_instr;
      q_pc    <= d_pc;
    end
  end

endmodule

// File: rtl/fetch_pipeline.sv
// Instruction-fetch front end: PC register, STAGES-deep fetch pipe and
// jump-driven squash of in-flight instructions to the NOP opcode.
module fetch_pipeline
  import fetch_pipeline_pkg::*;
#(
  parameter int unsigned        ADDR_W   = ADDR_W_DEF,
  parameter int unsigned        INSTR_W  = INSTR_W_DEF,
  parameter int unsigned        STAGES   = STAGES_DEF,
  parameter logic [INSTR_W-1:0] NOP_OP   = INSTR_W'(NOP_OP_DEF),
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fetch_pipeline_if.slave       bus
);

  generate
    if (!stages_ok(STAGES)) begin : g_bad_stages
      $error("fetch_pipeline: STAGES=%0d outside supported range 1..4", STAGES);
    end
  endgenerate

  logic              take;
  logic              advance;
  logic [ADDR_W-1:0] pc_q;

  assign take    = bus.jmp | (bus.jmp_nz & ~bus.zero_flag);
  assign advance = ~take & ~bus.stall;

  // A taken jump overrides stall; stall freezes the PC otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else if (take) begin
      pc_q <= bus.jmp_addr;
    end else if (advance) begin
      pc_q <= pc_q + ADDR_W'(1);
    end
  end

  // Index 0 is the memory side; index k+1 is the output of stage k.
  logic [STAGES:0]              vld;
  logic [STAGES:0][INSTR_W-1:0] dat;
  logic [STAGES:0][ADDR_W-1:0]  spc;

  assign vld[0] = 1'b1;
  assign dat[0] = bus.pm_data;
  assign spc[0] = pc_q;

  generate
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      fetch_stage #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
      ) u_stage (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (take),
        .load    (advance),
        .d_valid (vld[i]),
        .d_instr (dat[i]),
        .d_pc    (spc[i]),
        .q_valid (vld[i+1]),
        .q_instr (dat[i+1]),
        .q_pc    (spc[i+1])
      );
    end
  endgenerate

  // Empty last slot or a jump this cycle presents a NOP with a zero address.
  always_comb begin
    bus.instr       = NOP_OP;
    bus.instr_valid = 1'b0;
    bus.instr_pc    = '0;
    if (vld[STAGES] && !take) begin
      bus.instr       = dat[STAGES];
      bus.instr_valid = 1'b1;
      bus.instr_pc    = spc[STAGES];
    end
  end

  assign bus.pc      = pc_q;
  assign bus.pm_addr = pc_q;
  assign bus.flush   = take;

endmodule

// File: tb/tb_fetch_pipeline.sv
// Scoreboard bench for fetch_pipeline: a queue-based fetch model predicts each
// cycle's outputs; a negedge monitor pops and compares them.
module tb_fetch_pipeline;

  localparam int unsigned AW  = 8;
  localparam int unsigned IW  = 8;
  localparam int unsigned ST  = 2;
  localparam logic [7:0]  NOP = 8'hC8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fetch_pipeline_if #(.ADDR_W(AW), .INSTR_W(IW)) bus();

  fetch_pipeline #(
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .STAGES   (ST),
    .NOP_OP   (NOP),
    .RESET_PC (8'h00)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [7:0] mem [256];
  assign bus.pm_data = mem[bus.pm_addr];

  typedef struct packed {
    logic [7:0] instr;
    logic       v;
    logic [7:0] ipc;
    logic [7:0] pc;
    logic       flush;
  } exp_t;

  typedef struct packed {
    logic       v;
    logic [7:0] a;
  } slot_t;

  exp_t  exp_q[$];
  slot_t pipe[$];
  logic [7:0] m_pc;
  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Model: a list of in-flight fetch addresses, oldest at the back.
  function automatic void model_reset();
    pipe.delete();
    for (int i = 0; i < int'(ST); i++) pipe.push_back('0);
    m_pc = 8'h00;
  endfunction

  function automatic bit model_take();
    return bus.jmp || (bus.jmp_nz && !bus.zero_flag);
  endfunction

  function automatic void model_edge();
    slot_t s;
    if (!reset_n) begin
      model_reset();
    end else if (model_take()) begin
      m_pc = bus.jmp_addr;
      for (int i = 0; i < pipe.size(); i++) pipe[i].v = 1'b0;
    end else if (!bus.stall) begin
      s.v = 1'b1;
      s.a = m_pc;
      pipe.push_front(s);
      void'(pipe.pop_back());
      m_pc = m_pc + 8'd1;
    end
  endfunction

  function automatic void push_expect();
    exp_t  e;
    slot_t last;
    bit    tk;
    last    = pipe[pipe.size()-1];
    tk      = model_take();
    e.pc    = m_pc;
    e.flush = tk;
    if (last.v && !tk) begin
      e.instr = mem[last.a];
      e.v     = 1'b1;
      e.ipc   = last.a;
    end else begin
      e.instr = NOP;
      e.v     = 1'b0;
      e.ipc   = 8'h00;
    end
    exp_q.push_back(e);
  endfunction

  task automatic step(input logic s, input logic j, input logic jn, input logic z,
                      input logic [7:0] a);
    @(posedge clk);
    model_edge();
    #1;
    bus.stall     = s;
    bus.jmp       = j;
    bus.jmp_nz    = jn;
    bus.zero_flag = z;
    bus.jmp_addr  = a;
    push_expect();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
  endtask

  // Changes reset mid-cycle; asserting it is checked before any further edge.
  task automatic set_reset(input logic r);
    @(posedge clk);
    model_edge();
    #1;
    bus.stall = 1'b0; bus.jmp = 1'b0; bus.jmp_nz = 1'b0;
    bus.zero_flag = 1'b1; bus.jmp_addr = 8'h00;
    reset_n = r;
    if (!r) model_reset();
    push_expect();
    if (!r) begin
      #1;
      chk("async_rst_pc", 32'(bus.pc), 32'h00);
      chk("async_rst_instr", 32'(bus.instr), 32'(NOP));
      chk("async_rst_valid", 32'(bus.instr_valid), 32'h0);
      chk("async_rst_ipc", 32'(bus.instr_pc), 32'h00);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("pc", 32'(bus.pc), 32'(e.pc));
      chk("pm_addr", 32'(bus.pm_addr), 32'(e.pc));
      chk("flush", 32'(bus.flush), 32'(e.flush));
      chk("instr_valid", 32'(bus.instr_valid), 32'(e.v));
      chk("instr", 32'(bus.instr), 32'(e.instr));
      chk("instr_pc", 32'(bus.instr_pc), 32'(e.ipc));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h10);
    bus.stall = 1'b0; bus.jmp = 1'b0; bus.jmp_nz = 1'b0;
    bus.zero_flag = 1'b1; bus.jmp_addr = 8'h00;
    model_reset();

    // Reset and fill.
    idle(2);
    set_reset(1'b1);
    idle(6);
    // Unconditional jump, then conditional not-taken and taken.
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h40);
    idle(6);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h70);
    idle(3);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h60);
    idle(5);
    // Stall, then stall together with a jump.
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    idle(4);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h20);
    idle(4);
    // PC wrap and back-to-back jumps.
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'hFC);
    idle(8);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h10);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h30);
    idle(4);

    // Random traffic with arbitrary memory contents.
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      step(r < 25, (r >= 25) && (r < 32), (r >= 32) && (r < 45),
           1'($urandom_range(0, 1)), 8'($urandom));
    end

    // Reset in the middle of a cycle, then resume.
    set_reset(1'b0);
    idle(2);
    set_reset(1'b1);
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 99));
      step(r < 20, (r >= 20) && (r < 28), (r >= 28) && (r < 40),
           1'($urandom_range(0, 1)), 8'($urandom));
    end
    idle(3);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_pipeline.md
# fetch_pipeline

Parametrised instruction-fetch front end for the micro_srom processor family. It replaces the fixed single-register fetch pipe and the hard-wired flush multiplexer with three things: a program counter, a STAGES-deep instruction pipeline carrying a valid bit and a PC per stage, and a decoder-facing stall. It sits between the program sequencer/program memory and the instruction decoder. On a taken jump or taken conditional jump it squashes every in-flight instruction to the NOP opcode.

## Interface
Parameters:
- ADDR_W, 8, program-memory address width; PC width.
- INSTR_W, 8, instruction width.
- STAGES, 1, pipeline depth between memory and decoder; legal range 1..4.
- NOP_OP, 8'hC8, opcode substituted for squashed or invalid slots.
- RESET_PC, 0, PC value loaded by reset.

Ports:
- clk, in, 1, single clock; all state updates on the rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- stall, in, 1, decoder not ready; holds the PC and all stages.
- jmp, in, 1, unconditional jump from the decoder.
- jmp_nz, in, 1, conditional jump from the decoder; taken when zero_flag = 0.
- zero_flag, in, 1, r_eq_0 from the computational unit.
- jmp_addr, in, ADDR_W, jump target.
- pm_data, in, INSTR_W, program memory read data, valid in the same cycle (memory clocked on ~clk).
- pm_addr, out, ADDR_W, program memory address; equal to pc.
- pc, out, ADDR_W, current fetch PC.
- instr, out, INSTR_W, instruction to the decoder.
- instr_pc, out, ADDR_W, address of instr; 0 when instr_valid = 0.
- instr_valid, out, 1, instr is a real fetched instruction.
- flush, out, 1, taken jump this cycle (combinational).

## Operation
- **take** = jmp | (jmp_nz & ~zero_flag). The flush output equals take.
- **Priority per edge:** reset, then take, then stall, then normal advance.
- **Normal advance** (no take, no stall):
  - pc <= pc + 1, wrapping from 2^ADDR_W-1 to 0.
  - Stage 0 <= {valid=1, pm_data, pc}.
  - Stage k <= stage k-1.
- **Stall** (no take): pc and all stages hold; pm_addr is unchanged.
- **Take:** pc <= jmp_addr and every stage valid <= 0, overriding stall. In the same cycle, instr is forced to NOP_OP and instr_valid to 0.
- **Output:** instr = last-stage data if that stage is valid and take = 0; otherwise NOP_OP.
- **Invalid stages:** the data field of an invalid stage is don't-care internally and never reaches instr.

## Timing
- **Reset values:** pc = pm_addr = RESET_PC, all stages invalid, instr = NOP_OP, instr_valid = 0, instr_pc = 0, flush follows its inputs.
- **Reset mid-operation:** clears all state immediately (asynchronously), with no edge needed.
- **Fetch latency:** the instruction at address A, presented on pm_addr in cycle t, appears on instr in cycle t+STAGES, plus one cycle for each stall cycle in between.
- **After reset release:** instr_valid first rises STAGES cycles after the first rising edge with reset_n = 1.
- **Jump:** with take asserted in cycle t, pm_addr = jmp_addr in cycle t+1 and the target appears on instr in cycle t+1+STAGES. The branch penalty is STAGES+1 NOP cycles, counting cycle t.
- **Take on consecutive cycles:** each one reloads the PC and re-flushes.

## Structure
- Shared package/header fetch_defs holds NOP_OP, the default widths and a STAGES range check (an elaborate-time error outside 1..4).
- One sub-module, fetch_stage: a single {valid, instr, pc} register with hold, clear and load controls. It is instantiated STAGES times in a generate loop.
- The PC register and the take logic live in the top level.

## Test plan
- **Reset:** with STAGES=2 and memory holding mem[i]=i+0x10, release reset → instr = 0xC8 with valid = 0 for 2 cycles, then 0x10, 0x11, 0x12 with instr_pc = 0, 1, 2.
- **Unconditional jump:** assert jmp for 1 cycle with jmp_addr = 0x40 → flush = 1 and instr = 0xC8 in that cycle. pm_addr = 0x40 next cycle; 3 NOP cycles in total, then instr = mem[0x40].
- **Conditional jump:** jmp_nz with zero_flag = 1 → no flush and the PC keeps incrementing. Repeat with zero_flag = 0 → behaves exactly as the unconditional jump.
- **Stall:** assert stall for 3 cycles while instr = mem[5] → instr, instr_pc and pc are held for 3 cycles. mem[6] appears the cycle after stall drops, with no instruction lost or duplicated.
- **Stall with jump:** stall and jmp together → the jump is taken, the PC loads jmp_addr and the pipeline empties.
- **Wrap and reset:** with pc = 0xFF and STAGES=4, advance → pc = 0x00 and instr_pc wraps correctly. Drop reset_n mid-cycle → all outputs reach their reset values before the next edge.
